gray_wptr_ctrl: RTL and testbench

Write-side pointer controller for the 16-entry PCS elastic buffer in the pcs25g receive path.
- Sequences writes into the buffer RAM and maintains a 5-bit binary write pointer (bit 4 = wrap).
- Publishes the pointer as a registered reflected-Gray code so the read domain can synchronise it.
- Computes full/level against the synchronised read Gray pointer, and runs the startup (prime) and overflow-recovery sequence.

---
 rtl/pcs25g_ebuf_pkg.sv | 15 +
 rtl/gray_ptr_dec.sv | 9 +
 rtl/gray_wptr_ctrl.sv | 92 +++++++++
 tb/tb_gray_wptr_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pcs25g_ebuf_pkg.sv
// pcs25g_ebuf_pkg: shared depth/width constants, controller states and Gray pointer helpers
package pcs25g_ebuf_pkg;
  localparam int EBUF_DEPTH = 16;
  localparam int PTR_W = 5;
  typedef enum logic [1:0] {IDLE, PRIME, RUN, RESYNC} ebuf_state_e;
  function automatic logic [PTR_W-1:0] bin2gray(input logic [PTR_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [PTR_W-1:0] gray2bin(input logic [PTR_W-1:0] g);
    logic [PTR_W-1:0] b;
    b[PTR_W-1] = g[PTR_W-1];
    for (int i = PTR_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/gray_ptr_dec.sv
// gray_ptr_dec: combinational reflected-Gray to binary pointer decoder
module gray_ptr_dec
  import pcs25g_ebuf_pkg::*;
(
  input  logic [PTR_W-1:0] i_gray,
  output logic [PTR_W-1:0] o_bin
);
  assign o_bin = gray2bin(i_gray);
endmodule

// File: rtl/gray_wptr_ctrl.sv
// gray_wptr_ctrl: elastic-buffer write pointer/prime/recovery controller; GRAY_WPTR_AFULL_EN adds afull
module gray_wptr_ctrl
  import pcs25g_ebuf_pkg::*;
#(
  parameter int PRIME_LVL  = 8,
  parameter int RESYNC_CYC = 4,
  parameter int AFULL_LVL  = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             lock,
  input  logic             wr_req,
  output logic             wr_ready,
  output logic             wr_en,
  output logic [3:0]       waddr,
  output logic [PTR_W-1:0] wgray,
  input  logic [PTR_W-1:0] rgray_sync,
  output logic             full,
  output logic [PTR_W-1:0] level,
  output logic             rd_start,
  output logic             buf_clr,
`ifdef GRAY_WPTR_AFULL_EN
  output logic             afull,
`endif
  output logic             ovf_err
);
  localparam logic [PTR_W-1:0] LP_PRIME = PTR_W'(PRIME_LVL);
  localparam logic [PTR_W-1:0] LP_FULL  = PTR_W'(EBUF_DEPTH);
  localparam logic [3:0]       LP_CNT   = 4'(RESYNC_CYC - 1);
  ebuf_state_e      r_state, w_nxt;
  logic [PTR_W-1:0] r_wbin, w_wbin_nxt, r_wgray, w_rbin, w_diff;
  logic [3:0]       r_cnt;
  logic             r_rd_start, r_ovf, w_act, w_ovf_ev;

  gray_ptr_dec u_rdec (.i_gray(rgray_sync), .o_bin(w_rbin));

  // a difference with the wrap bit set means 16 or more entries: clamp and call it full
  assign w_diff   = r_wbin - w_rbin;
  assign level    = w_diff[PTR_W-1] ? LP_FULL : w_diff;
  assign full     = (r_wgray == {~rgray_sync[4:3], rgray_sync[2:0]}) || w_diff[PTR_W-1];
  assign w_act    = (r_state == PRIME) || (r_state == RUN);
  assign w_ovf_ev = (r_state == RUN) && wr_req && full;

  always_ff @(posedge clk) r_state <= reset ? IDLE : w_nxt;

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    w_nxt = lock ? PRIME : IDLE;
      PRIME:   w_nxt = !lock ? RESYNC : (level >= LP_PRIME) ? RUN : PRIME;
      RUN:     w_nxt = (!lock || w_ovf_ev) ? RESYNC : RUN;
      RESYNC:  w_nxt = (r_cnt == 4'd0) ? IDLE : RESYNC;
      default: w_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_ready = w_act && !full;
    wr_en    = wr_req && wr_ready;
    buf_clr  = r_state == RESYNC;
  end

  assign w_wbin_nxt = ((w_nxt == IDLE) || (w_nxt == RESYNC)) ? '0 : r_wbin + PTR_W'(wr_en);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wbin     <= '0;
      r_wgray    <= '0;
      r_cnt      <= '0;
      r_rd_start <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_wbin     <= w_wbin_nxt;
      r_wgray    <= bin2gray(w_wbin_nxt);
      r_cnt      <= (r_state != RESYNC) ? LP_CNT : r_cnt - 4'd1;
      r_rd_start <= w_nxt == RUN;
      r_ovf      <= r_ovf || w_ovf_ev;
    end
  end

  assign waddr    = r_wbin[3:0];
  assign wgray    = r_wgray;
  assign rd_start = r_rd_start;
  assign ovf_err  = r_ovf;

`ifdef GRAY_WPTR_AFULL_EN
  localparam logic [PTR_W-1:0] LP_AFULL = PTR_W'(AFULL_LVL);
  logic r_afull;
  always_ff @(posedge clk) r_afull <= !reset && ((w_nxt == PRIME) || (w_nxt == RUN)) && (level >= LP_AFULL);
  assign afull = r_afull;
`endif
endmodule

// File: tb/tb_gray_wptr_ctrl.sv
// tb_gray_wptr_ctrl: vector table, corner sequences and random run against a counting model
module tb_gray_wptr_ctrl;
  localparam int PRIME_LVL  = 8;
  localparam int RESYNC_CYC = 4;
  localparam int AFULL_LVL  = 14;
  localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_RESYNC = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1, lock = 1'b0, wr_req = 1'b0;
  logic [4:0] rgray_sync = 5'd0;
  logic       wr_ready, wr_en, full, rd_start, buf_clr, ovf_err;
  logic [3:0] waddr;
  logic [4:0] wgray, level;
`ifdef GRAY_WPTR_AFULL_EN
  logic       afull;
`endif

  gray_wptr_ctrl #(.PRIME_LVL(PRIME_LVL), .RESYNC_CYC(RESYNC_CYC), .AFULL_LVL(AFULL_LVL)) dut (
    .clk(clk), .reset(reset), .lock(lock), .wr_req(wr_req), .wr_ready(wr_ready), .wr_en(wr_en),
    .waddr(waddr), .wgray(wgray), .rgray_sync(rgray_sync), .full(full), .level(level),
    .rd_start(rd_start), .buf_clr(buf_clr),
`ifdef GRAY_WPTR_AFULL_EN
    .afull(afull),
`endif
    .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int m_mode = M_IDLE, m_w = 0, m_r = 0, m_cnt = 0, e_lvl = 0;
  logic m_rs = 1'b0, m_ovf = 1'b0, m_af = 1'b0;
  logic e_full, e_ready, e_en, c_r, c_l, c_w;

  typedef struct {
    logic lk; logic wr; int rb; logic [4:0] wg; int lv; logic en; logic rd; logic fl; logic cl; logic ov;
  } vec_t;
  vec_t tv[24];

  function automatic logic [4:0] g5(input int b);
    logic [4:0] x;
    x = b[4:0];
    return x ^ (x >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic drv(input logic r, input logic l, input logic w, input int rb);
    int raw;
    @(negedge clk);
    reset = r; lock = l; wr_req = w; rgray_sync = g5(rb); m_r = rb & 31;
    #2;
    raw = (m_w - m_r) & 31;
    e_full = raw >= 16;
    e_lvl = e_full ? 16 : raw;
    e_ready = ((m_mode == M_PRIME) || (m_mode == M_RUN)) && !e_full;
    e_en = w && e_ready;
    c_r = r; c_l = l; c_w = w;
    chk("wgray", 32'(wgray), 32'(g5(m_w)));
    chk("waddr", 32'(waddr), 32'(m_w % 16));
    chk("level", 32'(level), e_lvl);
    chk("full", 32'(full), 32'(e_full));
    chk("wr_ready", 32'(wr_ready), 32'(e_ready));
    chk("wr_en", 32'(wr_en), 32'(e_en));
    chk("rd_start", 32'(rd_start), 32'(m_rs));
    chk("buf_clr", 32'(buf_clr), 32'(m_mode == M_RESYNC));
    chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
`ifdef GRAY_WPTR_AFULL_EN
    chk("afull", 32'(afull), 32'(m_af));
`endif
  endtask

  task automatic adv();
    int nm;
    @(posedge clk);
    nm = m_mode;
    if (c_r) begin
      nm = M_IDLE; m_w = 0; m_rs = 1'b0; m_ovf = 1'b0; m_af = 1'b0;
    end else begin
      if (m_mode == M_IDLE && c_l) nm = M_PRIME;
      else if (m_mode == M_PRIME && !c_l) nm = M_RESYNC;
      else if (m_mode == M_PRIME && e_lvl >= PRIME_LVL) begin nm = M_RUN; m_rs = 1'b1; end
      else if (m_mode == M_RUN && c_w && e_full) begin nm = M_RESYNC; m_ovf = 1'b1; end
      else if (m_mode == M_RUN && !c_l) nm = M_RESYNC;
      else if (m_mode == M_RESYNC) begin m_cnt--; if (m_cnt == 0) nm = M_IDLE; end
      if (nm == M_RESYNC && m_mode != M_RESYNC) begin m_cnt = RESYNC_CYC; m_rs = 1'b0; end
      m_af = ((nm == M_PRIME) || (nm == M_RUN)) && (e_lvl >= AFULL_LVL);
      m_w = ((nm == M_IDLE) || (nm == M_RESYNC)) ? 0 : (m_w + int'(e_en)) % 32;
    end
    m_mode = nm;
  endtask

  task automatic cyc(input logic r, input logic l, input logic w, input int rb);
    drv(r, l, w, rb);
    adv();
  endtask

  initial begin
    logic [4:0] pg;
    logic wrap;
    int n, rb;
    logic done, r, l, w;
    tv[0]  = '{1'b1, 1'b1, 0, 5'b00000, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 0, 5'b00000, 0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 0, 5'b00001, 1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 0, 5'b00011, 2,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 1'b1, 0, 5'b00010, 3,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 0, 5'b00110, 4,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b1, 0, 5'b00111, 5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 0, 5'b00101, 6,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 0, 5'b00100, 7,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[9]  = '{1'b1, 1'b1, 0, 5'b01100, 8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[10] = '{1'b1, 1'b1, 0, 5'b01101, 9,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[11] = '{1'b1, 1'b1, 0, 5'b01111, 10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[12] = '{1'b1, 1'b1, 0, 5'b01110, 11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[13] = '{1'b1, 1'b1, 0, 5'b01010, 12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[14] = '{1'b1, 1'b1, 0, 5'b01011, 13, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[15] = '{1'b1, 1'b1, 0, 5'b01001, 14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[16] = '{1'b1, 1'b1, 0, 5'b01000, 15, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tv[17] = '{1'b1, 1'b1, 0, 5'b11000, 16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    tv[18] = '{1'b1, 1'b0, 0, 5'b00000, 0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[19] = '{1'b1, 1'b0, 0, 5'b00000, 0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[20] = '{1'b1, 1'b0, 0, 5'b00000, 0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[21] = '{1'b1, 1'b0, 0, 5'b00000, 0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[22] = '{1'b1, 1'b0, 0, 5'b00000, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[23] = '{1'b1, 1'b0, 0, 5'b00000, 0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    repeat (3) @(posedge clk);
    cyc(1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 24; i++) begin
      drv(1'b0, tv[i].lk, tv[i].wr, tv[i].rb);
      chk("tv_wgray", 32'(wgray), 32'(tv[i].wg));
      chk("tv_level", 32'(level), tv[i].lv);
      chk("tv_wr_en", 32'(wr_en), 32'(tv[i].en));
      chk("tv_rd_start", 32'(rd_start), 32'(tv[i].rd));
      chk("tv_full", 32'(full), 32'(tv[i].fl));
      chk("tv_buf_clr", 32'(buf_clr), 32'(tv[i].cl));
      chk("tv_ovf_err", 32'(ovf_err), 32'(tv[i].ov));
      adv();
    end
    cyc(1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k < 10; k++) cyc(1'b0, 1'b1, 1'b1, 0);
    pg = 5'd0;
    wrap = 1'b0;
    for (int k = 0; k < 40; k++) begin
      drv(1'b0, 1'b1, 1'b1, (m_w - 4) & 31);
      if (k > 0) chk("gray_one_bit", 32'($countones(wgray ^ pg)), 32'd1);
      if (pg == 5'b10000 && wgray == 5'b00000) wrap = 1'b1;
      pg = wgray;
      adv();
    end
    chk("gray_wrap_31_0", 32'(wrap), 32'd1);
    drv(1'b0, 1'b1, 1'b0, (m_w - 5) & 31);
    chk("t4_level5", 32'(level), 32'd5);
    adv();
    cyc(1'b0, 1'b0, 1'b0, m_r);
    drv(1'b0, 1'b0, 1'b0, 0);
    chk("t4_clr", 32'(buf_clr), 32'd1);
    chk("t4_waddr", 32'(waddr), 32'd0);
    chk("t4_rd_start", 32'(rd_start), 32'd0);
    adv();
    n = 1;
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      drv(1'b0, 1'b0, 1'b0, 0);
      if (buf_clr) n++;
      else done = 1'b1;
      adv();
    end
    chk("t4_clr_cycles", n, RESYNC_CYC);
    drv(1'b0, 1'b1, 1'b1, 0);
    chk("t4_idle_ready", 32'(wr_ready), 32'd0);
    adv();
    drv(1'b0, 1'b1, 1'b1, 0);
    chk("t4_reprime_ready", 32'(wr_ready), 32'd1);
    adv();
    for (int i = 0; i < 40 && m_mode != M_RESYNC; i++) cyc(1'b0, 1'b1, 1'b1, 0);
    drv(1'b0, 1'b1, 1'b0, 0);
    chk("t5_in_resync", 32'(buf_clr), 32'd1);
    chk("t5_ovf_set", 32'(ovf_err), 32'd1);
    adv();
    cyc(1'b1, 1'b1, 1'b0, 0);
    drv(1'b0, 1'b0, 1'b0, 0);
    chk("t5_clr", 32'(buf_clr), 32'd0);
    chk("t5_ovf", 32'(ovf_err), 32'd0);
    chk("t5_rd_start", 32'(rd_start), 32'd0);
    chk("t5_wgray", 32'(wgray), 32'd0);
    chk("t5_ready", 32'(wr_ready), 32'd0);
    chk("t5_level", 32'(level), 32'd0);
    adv();
`ifdef GRAY_WPTR_AFULL_EN
    cyc(1'b1, 1'b0, 1'b0, 0);
    for (int k = 0; k <= 16; k++) begin
      drv(1'b0, 1'b1, 1'b1, 0);
      if (k == 14) chk("t6_afull_l13", 32'(afull), 32'd0);
      if (k == 15) chk("t6_afull_l14", 32'(afull), 32'd0);
      if (k == 16) chk("t6_afull_set", 32'(afull), 32'd1);
      adv();
    end
`endif
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 199) == 0;
      l = $urandom_range(0, 59) != 0;
      w = $urandom_range(0, 3) != 0;
      if (m_mode == M_IDLE || m_mode == M_RESYNC) rb = 0;
      else if (m_rs && ((m_w - m_r) & 31) > 0 && $urandom_range(0, 1) == 1) rb = (m_r + 1) & 31;
      else rb = m_r;
      cyc(r, l, w, rb);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
